// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for viterbi_decoder: feeds MSG_LEN payload symbols plus TBLEN zero tail
// symbols, collects MSG_LEN decoded bits, and reports completion or watchdog timeout.
module viterbi_frame_ctrl #(
    parameter int unsigned MSG_LEN   = 512,
    parameter int unsigned TBLEN     = 32,
    parameter int unsigned TO_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       start,
    output logic       busy,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [1:0] s_data,
    output logic       dec_RSTn,
    output logic       dec_valid,
    output logic [1:0] dec_data,
    input  logic       dec_out_valid,
    input  logic       dec_out,
    output logic       m_valid,
    output logic       m_data,
    output logic       frame_done,
    output logic       timeout_err
);

    localparam int unsigned CntW = $clog2(MSG_LEN + TBLEN + 1);
    localparam int unsigned WdW  = $clog2(TO_CYCLES + 1);

    localparam logic [CntW-1:0] LastPayload = CntW'(MSG_LEN - 1);
    localparam logic [CntW-1:0] LastTail    = CntW'(MSG_LEN + TBLEN - 1);
    localparam logic [CntW-1:0] MsgLen      = CntW'(MSG_LEN);
    localparam logic [WdW-1:0]  WdLast      = WdW'(TO_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StFeed, StFlush, StDrain, StDone} state_e;

    state_e          state_q;
    logic [CntW-1:0] in_cnt_q;
    logic [CntW-1:0] out_cnt_q;
    logic [WdW-1:0]  wd_cnt_q;
    logic            collect;

    // Decoded bits are forwarded only while a frame is in flight and the quota is not yet met.
    assign collect = ((state_q == StFeed) || (state_q == StFlush) || (state_q == StDrain)) &&
                     dec_out_valid && (out_cnt_q < MsgLen);

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q     <= StIdle;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            wd_cnt_q    <= '0;
            busy        <= 1'b0;
            s_ready     <= 1'b0;
            dec_RSTn    <= 1'b0;
            dec_valid   <= 1'b0;
            dec_data    <= 2'b00;
            m_valid     <= 1'b0;
            m_data      <= 1'b0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
            m_valid     <= collect;
            m_data      <= collect ? dec_out : 1'b0;
            if (collect) begin
                out_cnt_q <= out_cnt_q + 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    dec_valid <= 1'b0;
                    dec_data  <= 2'b00;
                    if (start) begin
                        state_q   <= StFeed;
                        busy      <= 1'b1;
                        s_ready   <= 1'b1;
                        dec_RSTn  <= 1'b1;
                        in_cnt_q  <= '0;
                        out_cnt_q <= '0;
                        wd_cnt_q  <= '0;
                    end
                end
                StFeed: begin
                    if (s_valid && s_ready) begin
                        dec_valid <= 1'b1;
                        dec_data  <= s_data;
                        in_cnt_q  <= in_cnt_q + 1'b1;
                        if (in_cnt_q == LastPayload) begin
                            state_q <= StFlush;
                            s_ready <= 1'b0;
                        end
                    end else begin
                        dec_valid <= 1'b0;
                    end
                end
                StFlush: begin
                    dec_valid <= 1'b1;
                    dec_data  <= 2'b00;
                    in_cnt_q  <= in_cnt_q + 1'b1;
                    if (in_cnt_q == LastTail) begin
                        state_q  <= StDrain;
                        wd_cnt_q <= '0;
                    end
                end
                StDrain: begin
                    dec_valid <= 1'b0;
                    dec_data  <= 2'b00;
                    // A valid bit on the expiry cycle restarts the watchdog instead of timing out.
                    if (out_cnt_q == MsgLen) begin
                        state_q    <= StDone;
                        frame_done <= 1'b1;
                    end else if (dec_out_valid) begin
                        wd_cnt_q <= '0;
                    end else if (wd_cnt_q == WdLast) begin
                        state_q     <= StDone;
                        frame_done  <= 1'b1;
                        timeout_err <= 1'b1;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    state_q   <= StIdle;
                    busy      <= 1'b0;
                    dec_RSTn  <= 1'b0;
                    dec_valid <= 1'b0;
                    dec_data  <= 2'b00;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Bench for viterbi_frame_ctrl: a stand-in decoder (parity of each symbol, fixed latency) plus
// a per-cycle scoreboard over the symbol stream sent to the decoder and the decoded bit stream.
module tb_viterbi_frame_ctrl;

    localparam int MSG_LEN   = 512;
    localparam int TBLEN     = 32;
    localparam int TO_CYCLES = 4096;

    logic       clk = 1'b0;
    logic       RST = 1'b1;
    logic       start = 1'b0;
    logic       busy;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [1:0] s_data = 2'b00;
    logic       dec_RSTn;
    logic       dec_valid;
    logic [1:0] dec_data;
    logic       dec_out_valid = 1'b0;
    logic       dec_out = 1'b0;
    logic       m_valid;
    logic       m_data;
    logic       frame_done;
    logic       timeout_err;

    viterbi_frame_ctrl #(
        .MSG_LEN  (MSG_LEN),
        .TBLEN    (TBLEN),
        .TO_CYCLES(TO_CYCLES)
    ) dut (
        .clk          (clk),
        .RST          (RST),
        .start        (start),
        .busy         (busy),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .dec_RSTn     (dec_RSTn),
        .dec_valid    (dec_valid),
        .dec_data     (dec_data),
        .dec_out_valid(dec_out_valid),
        .dec_out      (dec_out),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .frame_done   (frame_done),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [1:0] payload [MSG_LEN];
    logic       gold    [MSG_LEN];

    // Per-frame scoreboard state
    int   d_cnt = 0;
    int   m_cnt = 0;
    int   done_cnt = 0;
    int   to_cnt = 0;
    int   cyc = 0;
    int   last_dv_cycle = 0;
    int   done_cycle = 0;
    logic [3:0] first4 = 4'h0;
    logic hs_prev = 1'b0;
    logic cmp_en = 1'b0;

    // Stand-in decoder controls
    int   lag = TBLEN;
    logic silent = 1'b0;
    logic [1:0] dq [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stand-in decoder: bit j = parity of symbol j, released once `lag` later symbols arrived.
    always @(posedge clk) begin
        logic [1:0] sym;
        if (!dec_RSTn) begin
            dq.delete();
            dec_out_valid <= 1'b0;
            dec_out       <= 1'b0;
        end else begin
            dec_out_valid <= 1'b0;
            if (dec_valid) begin
                dq.push_back(dec_data);
                if (!silent && dq.size() > lag) begin
                    sym = dq.pop_front();
                    dec_out_valid <= 1'b1;
                    dec_out       <= ^sym;
                end
            end
        end
    end

    always @(posedge clk) begin
        hs_prev = s_valid && s_ready && !RST;
        cyc++;
    end

    // Scoreboard: decoder input stream = accepted payload in order then TBLEN zeros, with
    // dec_valid one cycle behind each handshake; output stream = golden bits, at most MSG_LEN.
    always @(negedge clk) begin
        logic       exp_dv;
        logic [1:0] exp_d;
        if (cmp_en) begin
            exp_dv = (d_cnt < MSG_LEN) ? hs_prev : (d_cnt < MSG_LEN + TBLEN);
            chk("dec_valid", dec_valid, exp_dv);
            if (dec_valid) begin
                exp_d = (d_cnt < MSG_LEN) ? payload[d_cnt] : 2'b00;
                chk("dec_data", dec_data, exp_d);
                d_cnt++;
                if (d_cnt == MSG_LEN + TBLEN) last_dv_cycle = cyc;
            end
            if (m_valid) begin
                if (m_cnt >= MSG_LEN) begin
                    chk("m_overflow", m_cnt, MSG_LEN - 1);
                end else begin
                    chk("m_data", m_data, gold[m_cnt]);
                    if (m_cnt < 4) first4[m_cnt] = m_data;
                end
                m_cnt++;
            end
            if (frame_done || timeout_err) begin
                chk("done_with_timeout", frame_done, 1'b1);
                if (frame_done) begin
                    done_cnt++;
                    done_cycle = cyc;
                end
                if (timeout_err) to_cnt++;
            end
        end
    end

    task automatic start_frame(input int lag_v, input logic silent_v);
        @(posedge clk);
        d_cnt = 0;
        m_cnt = 0;
        done_cnt = 0;
        to_cnt = 0;
        first4 = 4'h0;
        lag = lag_v;
        silent = silent_v;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", busy, 1'b1);
        chk("start_s_ready", s_ready, 1'b1);
        chk("start_dec_RSTn", dec_RSTn, 1'b1);
    endtask

    // Feeds the payload; gap toggles s_valid, start_at pulses start, rst_at aborts with RST.
    task automatic feed(input logic gap, input int start_at, input int rst_at);
        int   idx = 0;
        int   guard = 0;
        logic tog = 1'b1;
        logic acc;
        while (idx < MSG_LEN) begin
            @(negedge clk);
            if (idx == rst_at) begin
                s_valid = 1'b0;
                RST = 1'b1;
                return;
            end
            s_valid = gap ? tog : 1'b1;
            tog = ~tog;
            s_data = payload[idx];
            start = (idx == start_at);
            acc = s_valid && s_ready;
            @(posedge clk);
            if (acc) idx++;
            guard++;
            if (guard > 4 * MSG_LEN) begin
                chk("feed_timeout", idx, MSG_LEN);
                break;
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input logic start_in_done);
        int n = 0;
        while (!frame_done && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!frame_done) begin
            chk("frame_done_seen", 0, 1);
        end else if (start_in_done) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk("done_start_ignored_busy", busy, 1'b0);
        end
    endtask

    task automatic end_frame(input int exp_m, input int exp_to);
        repeat (4) @(negedge clk);
        chk("m_count", m_cnt, exp_m);
        chk("done_count", done_cnt, 1);
        chk("timeout_count", to_cnt, exp_to);
        chk("dec_symbols", d_cnt, MSG_LEN + TBLEN);
        chk("idle_busy", busy, 1'b0);
        chk("idle_dec_RSTn", dec_RSTn, 1'b0);
        chk("idle_s_ready", s_ready, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_s_ready"}, s_ready, 1'b0);
        chk({tag, "_dec_RSTn"}, dec_RSTn, 1'b0);
        chk({tag, "_dec_valid"}, dec_valid, 1'b0);
        chk({tag, "_dec_data"}, dec_data, 2'b00);
        chk({tag, "_m_valid"}, m_valid, 1'b0);
        chk({tag, "_m_data"}, m_data, 1'b0);
        chk({tag, "_frame_done"}, frame_done, 1'b0);
        chk({tag, "_timeout_err"}, timeout_err, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < MSG_LEN; i++) begin
            payload[i] = 2'((i * 7 + i / 3) ^ (i >> 2));
        end
        payload[0] = 2'b11;
        payload[1] = 2'b01;
        payload[2] = 2'b10;
        payload[3] = 2'b00;
        for (int i = 0; i < MSG_LEN; i++) gold[i] = ^payload[i];

        // Reset, with start held high to show reset priority
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        chk_all_zero("reset");
        RST = 1'b0;
        @(negedge clk);
        chk_all_zero("post_reset");
        cmp_en = 1'b1;

        // 1: continuous stream
        start_frame(TBLEN, 1'b0);
        feed(1'b0, -1, -1);
        wait_done(2000, 1'b0);
        end_frame(MSG_LEN, 0);
        chk("first4_bits", first4, 4'b0110);

        // 2: s_valid toggling every cycle
        start_frame(TBLEN, 1'b0);
        feed(1'b1, -1, -1);
        wait_done(2000, 1'b0);
        end_frame(MSG_LEN, 0);

        // 3: silent decoder -> watchdog
        start_frame(TBLEN, 1'b1);
        feed(1'b0, -1, -1);
        wait_done(TO_CYCLES + 1000, 1'b0);
        end_frame(0, 1);
        chk("timeout_latency", done_cycle - last_dv_cycle, TO_CYCLES);

        // 4: reset mid-FEED, then a clean frame
        start_frame(TBLEN, 1'b0);
        feed(1'b0, -1, 200);
        @(negedge clk);
        chk_all_zero("midrst");
        RST = 1'b0;
        repeat (20) @(negedge clk);
        chk("midrst_no_done", done_cnt, 0);
        chk("midrst_idle", busy, 1'b0);
        start_frame(TBLEN, 1'b0);
        feed(1'b0, -1, -1);
        wait_done(2000, 1'b0);
        end_frame(MSG_LEN, 0);

        // 5: start pulses during FEED and in the DONE cycle
        start_frame(TBLEN, 1'b0);
        feed(1'b0, 10, -1);
        wait_done(2000, 1'b1);
        repeat (5) @(negedge clk);
        chk("start_in_done_idle", busy, 1'b0);
        end_frame(MSG_LEN, 0);

        // 6: decoder emits MSG_LEN+8 bits; the extras must be dropped
        start_frame(TBLEN - 8, 1'b0);
        feed(1'b0, -1, -1);
        wait_done(2000, 1'b0);
        end_frame(MSG_LEN, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
